// File: rtl/serial_add_sequencer_if.sv
// rtl/serial_add_sequencer_if.sv - request/result bundle for the serial add/subtract unit
//
// Signals:
//   start        request, accepted only while busy=0
//   A, B         operands, sampled on the accepting edge only
//   Sign         1 = signed flag semantics, 0 = unsigned
//   Sub          1 = A-B, 0 = A+B
//   busy         slices are being computed
//   done         one-cycle pulse when S/Z/V/N are valid
//   S, Z, V, N   result and zero/overflow-carry/negative flags
// Modports: master drives the request side, slave is the sequencer.
interface serial_add_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Sign;
   logic             Sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Z;
   logic             V;
   logic             N;

   modport master (
      output start, A, B, Sign, Sub,
      input  busy, done, S, Z, V, N
   );

   modport slave (
      input  start, A, B, Sign, Sub,
      output busy, done, S, Z, V, N
   );
endinterface

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - multi-cycle add/subtract through one SLICE-bit carry slice
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    serial_add_sequencer_if.slave (start/A/B/Sign/Sub in, busy/done/S/Z/V/N out)
// Operands are captured on the accepting edge; WIDTH/SLICE RUN cycles follow,
// then a single DONE cycle in which S/Z/V/N become valid.
module serial_add_sequencer #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_add_sequencer_if.slave bus
);
   localparam int NSTEP  = WIDTH / SLICE;
   localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, next_state;

   logic [WIDTH-1:0]  a_reg;
   logic [WIDTH-1:0]  b_reg;      // already inverted for subtraction
   logic [WIDTH-1:0]  res;        // partial result, filled from the top
   logic              carry;
   logic              sign_reg;
   logic              sub_reg;
   logic [STEP_W-1:0] step;

   logic [WIDTH-1:0]  s_reg;
   logic              z_reg;
   logic              v_reg;
   logic              n_reg;

   logic              accept;
   logic              busy_c;
   logic              done_c;
   logic              last_step;

   logic [SLICE:0]    slice_full;   // slice sum with carry-out in the top bit
   logic [SLICE-1:0]  slice_low;    // lower SLICE-1 bits; top bit is carry into slice MSB
   logic [WIDTH-1:0]  res_next;
   logic              fin_c_out;
   logic              fin_c_msb;

   // Carry slice and result shift
   always_comb begin
      slice_full = {1'b0, a_reg[SLICE-1:0]} + {1'b0, b_reg[SLICE-1:0]}
                 + {{SLICE{1'b0}}, carry};
      slice_low  = {1'b0, a_reg[SLICE-2:0]} + {1'b0, b_reg[SLICE-2:0]}
                 + {{(SLICE-1){1'b0}}, carry};
      res_next   = {slice_full[SLICE-1:0], res[WIDTH-1:SLICE]};
      // On the last step the slice holds the operand MSB, so its internal
      // carry into the top bit is the carry into the word MSB.
      fin_c_out  = slice_full[SLICE];
      fin_c_msb  = slice_low[SLICE-1];
      last_step  = (step == STEP_W'(NSTEP - 1));
   end

   // Next-state and handshake outputs
   always_comb begin
      next_state = state;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            if (last_step) begin
               next_state = DONE;
            end
         end
         DONE: begin
            done_c = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg    <= '0;
         b_reg    <= '0;
         res      <= '0;
         carry    <= 1'b0;
         sign_reg <= 1'b0;
         sub_reg  <= 1'b0;
         step     <= '0;
         s_reg    <= '0;
         z_reg    <= 1'b0;
         v_reg    <= 1'b0;
         n_reg    <= 1'b0;
      end else if (accept) begin
         a_reg    <= bus.A;
         b_reg    <= bus.B ^ {WIDTH{bus.Sub}};
         sign_reg <= bus.Sign;
         sub_reg  <= bus.Sub;
         carry    <= bus.Sub;          // +1 completes the two's-complement of B
         res      <= '0;
         step     <= '0;
      end else if (state == RUN) begin
         a_reg <= a_reg >> SLICE;
         b_reg <= b_reg >> SLICE;
         res   <= res_next;
         carry <= fin_c_out;
         if (last_step) begin
            s_reg <= res_next;
            z_reg <= (res_next == '0);
            if (sign_reg) begin
               n_reg <= res_next[WIDTH-1];
               v_reg <= fin_c_msb ^ fin_c_out;
            end else begin
               n_reg <= 1'b0;
               v_reg <= sub_reg ? ~fin_c_out : fin_c_out;  // borrow on subtract
            end
         end else begin
            step <= step + STEP_W'(1);
         end
      end
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.S    = s_reg;
   assign bus.Z    = z_reg;
   assign bus.V    = v_reg;
   assign bus.N    = n_reg;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - self-checking bench for serial_add_sequencer
module tb_serial_add_sequencer;
   localparam int WIDTH = 32;
   localparam int NSTEP = 8;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sign;
      logic        sub;
      logic [31:0] s;
      logic        z;
      logic        v;
      logic        n;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

   serial_add_sequencer #(.WIDTH(WIDTH), .SLICE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // done must never coincide with busy
   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_with_busy: busy %b expected 0", bus.busy);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model built from operand signs and full-width compare.
   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sign, input logic sub);
      vec_t r;
      logic [32:0] full;
      r.a = a; r.b = b; r.sign = sign; r.sub = sub;
      full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      r.s = full[31:0];
      r.z = (r.s == 32'd0);
      if (sign) begin
         r.n = r.s[31];
         if (sub) r.v = (a[31] != b[31]) && (r.s[31] != a[31]);
         else     r.v = (a[31] == b[31]) && (r.s[31] != a[31]);
      end else begin
         r.n = 1'b0;
         r.v = sub ? (a < b) : full[32];
      end
      return r;
   endfunction

   // Issue one op, wait for done; check latency, busy length, result, pulse width.
   task automatic run_op(input vec_t v, input string tag, input bit check_drop);
      int  lat;
      int  bcnt;
      bit  seen;
      bus.A = v.a; bus.B = v.b; bus.Sign = v.sign; bus.Sub = v.sub;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 0; bcnt = 0; seen = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         if (bus.done === 1'b1) begin
            lat  = i;
            seen = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) bcnt++;
         tick();
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no done within 20 edges", tag);
      end else begin
         check({tag, "_latency"}, lat, NSTEP);
         check({tag, "_busy_cycles"}, bcnt, NSTEP);
         check({tag, "_S"}, bus.S, v.s);
         check({tag, "_Z"}, {31'd0, bus.Z}, {31'd0, v.z});
         check({tag, "_V"}, {31'd0, bus.V}, {31'd0, v.v});
         check({tag, "_N"}, {31'd0, bus.N}, {31'd0, v.n});
         if (check_drop) begin
            tick();
            check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
         end
      end
   endtask

   vec_t tbl [10];
   vec_t r;
   int   dcnt;

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Sign = 1'b0; bus.Sub = 1'b0;

      //          a             b             sg    sb    s             z     v     n
      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};
      tbl[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{32'h00000003, 32'h00000003, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};

      tick(); tick();
      reset = 1'b0;
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_S", bus.S, 32'd0);
      check("reset_ZVN", {29'd0, bus.Z, bus.V, bus.N}, 32'd0);
      tick();

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i], $sformatf("vec%0d", i), 1'b1);
         tick();
      end

      // Start while busy is ignored; start in DONE cycle is accepted.
      bus.A = 32'd1; bus.B = 32'd2; bus.Sign = 1'b0; bus.Sub = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      bus.A = 32'h0000FFFF; bus.B = 32'h0000FFFF; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 20 && bus.done !== 1'b1; i++) begin
         tick();
         dcnt++;
      end
      check("ignore_done_seen", {31'd0, bus.done}, 32'd1);
      check("ignore_S", bus.S, 32'd3);
      bus.A = 32'd10; bus.B = 32'd20; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("b2b_busy", {31'd0, bus.busy}, 32'd1);
      check("b2b_done_drop", {31'd0, bus.done}, 32'd0);
      check("b2b_hold_S", bus.S, 32'd3);
      tick(); tick(); tick();
      check("b2b_hold_mid_S", bus.S, 32'd3);
      dcnt = 3;
      while (bus.done !== 1'b1 && dcnt < 20) begin
         tick();
         dcnt++;
      end
      check("b2b_latency", dcnt, NSTEP);
      check("b2b_S", bus.S, 32'd30);
      tick();

      // Reset mid-RUN aborts with no done pulse.
      bus.A = 32'h12345678; bus.B = 32'h11111111; bus.Sign = 1'b0; bus.Sub = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      check("abort_S", bus.S, 32'd0);
      check("abort_ZVN", {29'd0, bus.Z, bus.V, bus.N}, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) dcnt++;
         tick();
      end
      check("abort_no_done", dcnt, 0);
      run_op(tbl[6], "after_abort", 1'b1);
      tick();

      for (int i = 0; i < 1000; i++) begin
         r = model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         run_op(r, "rand", 1'b0);
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
